mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: 64-word data memory behind a wait-state FSM that
// freezes upstream for WAIT_CYCLES cycles per access, plus the MEM/WB register.
module mem_stage #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic        wb_en_in,
  input  logic [3:0]  dest_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  output logic        freeze,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [3:0]  dest_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_result,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_W    = 3'(WAIT_CYCLES);
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  state_t      state_r, state_nxt_s;
  logic [2:0]  cnt_r, cnt_nxt_s;
  logic        req_s, freeze_s, complete_s, in_range_s, we_s;
  logic [31:0] offset_s;
  logic [5:0]  idx_s;
  logic [31:0] mem_r [0:63];

  assign req_s      = mem_r_en | mem_w_en;
  assign offset_s   = alu_result - BASE_ADDR;
  assign in_range_s = (alu_result >= BASE_ADDR) && (offset_s < 32'd256);
  assign idx_s      = offset_s[7:2];
  // Writes are suppressed while reset is held so an aborted access never lands.
  assign we_s       = complete_s & mem_w_en & in_range_s & rst;
  assign freeze     = freeze_s;

  // Next-state, counter and freeze/complete decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    freeze_s    = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && (WAIT_W != 3'd0)) begin
          freeze_s  = 1'b1;
          cnt_nxt_s = 3'd1;
          if (WAIT_W == 3'd1) begin
            state_nxt_s = COMPLETE;
          end else begin
            state_nxt_s = BUSY;
          end
        end else begin
          complete_s = req_s;
        end
      end
      BUSY: begin
        freeze_s  = 1'b1;
        cnt_nxt_s = cnt_r + 3'd1;
        if (cnt_r == WAIT_LAST) begin
          state_nxt_s = COMPLETE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      COMPLETE: begin
        complete_s  = 1'b1;
        cnt_nxt_s   = 3'd0;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // MEM/WB register: bubble while frozen, otherwise capture the instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      dest_out       <= 4'd0;
      alu_result_out <= 32'd0;
      mem_result     <= 32'd0;
      addr_err       <= 1'b0;
    end else if (freeze_s) begin
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      dest_out       <= 4'd0;
      alu_result_out <= 32'd0;
      mem_result     <= 32'd0;
      addr_err       <= 1'b0;
    end else begin
      wb_en_out      <= wb_en_in;
      mem_r_en_out   <= mem_r_en;
      dest_out       <= dest_in;
      alu_result_out <= alu_result;
      mem_result     <= (mem_r_en && in_range_s) ? mem_r[idx_s] : 32'd0;
      addr_err       <= req_s & ~in_range_s;
    end
  end

  // Data memory; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[idx_s] <= val_rm;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a latency-level model predicts freeze and the
// MEM/WB register each cycle for a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance.
module tb_mem_stage;

  localparam logic [31:0] BASE = 32'd1024;

  typedef struct packed {
    logic        r;
    logic        w;
    logic        wb;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] rm;
  } in_t;

  typedef struct packed {
    logic        wb;
    logic        rd;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] mres;
    logic        err;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;
  in_t  in0, in1;
  out_t out0, out1;
  logic fz0, fz1;
  logic        o0_wb, o0_rd, o0_err, o1_wb, o1_rd, o1_err;
  logic [3:0]  o0_dest, o1_dest;
  logic [31:0] o0_alu, o0_mres, o1_alu, o1_mres;

  out_t exp_reg [2];
  out_t nxt [2];
  logic exp_fz [2];
  logic [31:0] mdl_mem [2][64];
  int n_vec = 0;
  int n_err = 0;
  int fz_cnt [2];
  int err_cnt [2];

  always #5 clk = ~clk;

  mem_stage #(.WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .mem_r_en(in0.r), .mem_w_en(in0.w), .wb_en_in(in0.wb),
    .dest_in(in0.dest), .alu_result(in0.alu), .val_rm(in0.rm), .freeze(fz0),
    .wb_en_out(o0_wb), .mem_r_en_out(o0_rd), .dest_out(o0_dest),
    .alu_result_out(o0_alu), .mem_result(o0_mres), .addr_err(o0_err)
  );

  mem_stage #(.WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en(in1.r), .mem_w_en(in1.w), .wb_en_in(in1.wb),
    .dest_in(in1.dest), .alu_result(in1.alu), .val_rm(in1.rm), .freeze(fz1),
    .wb_en_out(o1_wb), .mem_r_en_out(o1_rd), .dest_out(o1_dest),
    .alu_result_out(o1_alu), .mem_result(o1_mres), .addr_err(o1_err)
  );

  assign out0 = {o0_wb, o0_rd, o0_dest, o0_alu, o0_mres, o0_err};
  assign out1 = {o1_wb, o1_rd, o1_dest, o1_alu, o1_mres, o1_err};

  function automatic int wait_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic logic fz_of(input int u);
    return (u == 0) ? fz0 : fz1;
  endfunction

  function automatic out_t out_of(input int u);
    return (u == 0) ? out0 : out1;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int u, input in_t iv);
    if (u == 0) begin
      in0 = iv;
      in1 = '0;
    end else begin
      in1 = iv;
      in0 = '0;
    end
  endtask

  // One instruction: memory ops take WAIT+1 cycles, the first WAIT frozen.
  task automatic op(input int u, input logic r, input logic w, input logic wb,
                    input logic [3:0] dest, input logic [31:0] addr, input logic [31:0] data);
    in_t  iv;
    out_t res;
    int   lat;
    int   idx;
    logic inr;
    iv = {r, w, wb, dest, addr, data};
    lat = (r || w) ? wait_of(u) + 1 : 1;
    inr = (addr >= BASE) && (addr < BASE + 32'd256);
    idx = int'((addr - BASE) >> 2) & 63;
    res = '0;
    res.wb = wb;
    res.rd = r;
    res.dest = dest;
    res.alu = addr;
    res.mres = (r && inr) ? mdl_mem[u][idx] : 32'd0;
    res.err = (r || w) && !inr;
    for (int i = 0; i < lat; i++) begin
      drive(u, iv);
      exp_fz[u] = (i < lat - 1);
      exp_fz[1-u] = 1'b0;
      nxt[u] = (i < lat - 1) ? out_t'('0) : res;
      nxt[1-u] = '0;
      @(posedge clk);
      #1;
    end
    if (w && inr) mdl_mem[u][idx] = data;
  endtask

  always @(posedge clk) begin
    exp_reg[0] <= nxt[0];
    exp_reg[1] <= nxt[1];
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("freeze%0d", u), 96'(fz_of(u)), 96'(exp_fz[u]));
        chk($sformatf("memwb%0d", u), 96'(out_of(u)), 96'(exp_reg[u]));
        if (fz_of(u)) fz_cnt[u]++;
        if (out_of(u).err) err_cnt[u]++;
      end
    end
  end

  initial begin
    int f0, e0;
    in0 = '0;
    in1 = '0;
    for (int u = 0; u < 2; u++) begin
      exp_fz[u] = 1'b0;
      nxt[u] = '0;
      fz_cnt[u] = 0;
      err_cnt[u] = 0;
    end
    #3;
    chk("rst_out0", 96'(out0), 96'd0);
    chk("rst_out1", 96'(out1), 96'd0);
    chk("rst_fz0", 96'(fz0), 96'd0);
    #5 rst = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;

    // Store then load at 1028, then a plain ALU op.
    f0 = fz_cnt[0];
    op(0, 1'b0, 1'b1, 1'b0, 4'd3, 32'd1028, 32'hDEADBEEF);
    chk("st_fz_cycles", 96'(fz_cnt[0] - f0), 96'd2);
    chk("st_wb_out", 96'(o0_wb), 96'd0);
    f0 = fz_cnt[0];
    op(0, 1'b1, 1'b0, 1'b1, 4'd5, 32'd1028, 32'd0);
    chk("ld_fz_cycles", 96'(fz_cnt[0] - f0), 96'd2);
    chk("ld_data", 96'(o0_mres), 96'hDEADBEEF);
    chk("ld_rd_en", 96'(o0_rd), 96'd1);
    chk("ld_dest", 96'(o0_dest), 96'd5);
    f0 = fz_cnt[0];
    op(0, 1'b0, 1'b0, 1'b1, 4'd7, 32'h5, 32'd0);
    chk("alu_fz", 96'(fz_cnt[0] - f0), 96'd0);
    chk("alu_val", 96'(o0_alu), 96'h5);
    chk("alu_wb", 96'(o0_wb), 96'd1);
    op(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    // Fill the edge words, then out-of-range accesses.
    op(0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd1024, 32'h00000A0A);
    op(0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd1276, 32'h63636363);
    e0 = err_cnt[0];
    op(0, 1'b1, 1'b0, 1'b1, 4'd1, 32'd1280, 32'd0);
    chk("oor_ld_data", 96'(o0_mres), 96'd0);
    chk("oor_ld_err", 96'(o0_err), 96'd1);
    op(0, 1'b0, 1'b1, 1'b0, 4'd2, 32'd1020, 32'hBAD0BAD0);
    op(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("oor_err_pulses", 96'(err_cnt[0] - e0), 96'd2);
    op(0, 1'b1, 1'b0, 1'b1, 4'd4, 32'd1276, 32'd0);
    chk("word63_kept", 96'(o0_mres), 96'h63636363);
    op(0, 1'b1, 1'b0, 1'b1, 4'd6, 32'd1027, 32'd0);
    chk("word0_lowbits", 96'(o0_mres), 96'h00000A0A);
    op(0, 1'b1, 1'b0, 1'b1, 4'd8, 32'd1031, 32'd0);
    chk("word1_lowbits", 96'(o0_mres), 96'hDEADBEEF);

    // Reset in the middle of a store to word 2.
    op(0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd1032, 32'h11112222);
    drive(0, {1'b0, 1'b1, 1'b0, 4'd9, 32'd1032, 32'h99998888});
    exp_fz[0] = 1'b1;
    nxt[0] = '0;
    @(posedge clk);
    #1;
    chk("abort_busy_fz", 96'(fz0), 96'd1);
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("abort_out0", 96'(out0), 96'd0);
    in0 = '0;
    exp_fz[0] = 1'b0;
    #1;
    chk("abort_fz_low", 96'(fz0), 96'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    op(0, 1'b1, 1'b0, 1'b1, 4'd2, 32'd1032, 32'd0);
    chk("word2_kept", 96'(o0_mres), 96'h11112222);

    // Zero-wait instance: store then load at 1040, freeze never rises.
    f0 = fz_cnt[1];
    op(1, 1'b0, 1'b1, 1'b0, 4'd1, 32'd1040, 32'hCAFEF00D);
    op(1, 1'b1, 1'b0, 1'b1, 4'd10, 32'd1040, 32'd0);
    chk("w0_ld_data", 96'(o1_mres), 96'hCAFEF00D);
    op(1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("w0_fz_never", 96'(fz_cnt[1] - f0), 96'd0);

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
